// File: rtl/conv_pkg.sv
// Shared types for the convolution engine and its upstream loader.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
//
// Contents:
//   conv_state_t - engine FSM state encoding (IDLE, FETCH, DRAIN, OUT, DONE)
//   calc_accw    - accumulator width able to hold B plus MAXK*MAXK full
//                  INW x INW products without overflow
package conv_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      DRAIN = 3'd2,
      OUT   = 3'd3,
      DONE  = 3'd4
   } conv_state_t;

   // 2*INW bits per product, plus enough headroom for MAXK*MAXK products and B.
   function automatic int calc_accw(input int inw, input int maxk);
      return 2 * inw + $clog2(maxk * maxk + 1);
   endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate for one convolution output word.
// Latency: product of x_in*w_in lands in acc on the edge where en is high.
// Backpressure: none; the caller gates en, load and clear.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   clear           - zero the accumulator (highest priority after reset)
//   load, load_val  - load sign-extended load_val (the bias)
//   en, x_in, w_in  - accumulate signed x_in*w_in
//   acc             - ACCW-bit two's-complement accumulator
module conv_mac
   import conv_pkg::*;
#(
   parameter int INW  = 24,
   parameter int MAXK = 4,
   parameter int ACCW = calc_accw(INW, MAXK)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            load,
   input  logic [INW-1:0]  load_val,
   input  logic            en,
   input  logic [INW-1:0]  x_in,
   input  logic [INW-1:0]  w_in,
   output logic [ACCW-1:0] acc
);

   logic signed [2*INW-1:0] prod;
   logic [ACCW-1:0]         prod_ext;
   logic [ACCW-1:0]         load_ext;

   assign prod     = $signed(x_in) * $signed(w_in);
   assign prod_ext = {{(ACCW-2*INW){prod[2*INW-1]}}, prod};
   assign load_ext = {{(ACCW-INW){load_val[INW-1]}}, load_val};

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         acc <= '0;
      end else if (load) begin
         acc <= load_ext;
      end else if (en) begin
         acc <= acc + prod_ext;
      end
   end

endmodule

// File: rtl/conv_engine.sv
// 2-D valid convolution of an R x C matrix X with a KxK kernel W plus bias B.
// Latency: first address cycle through first AXIS_TVALID cycle spans K*K+2 cycles.
// Backpressure: AXIS_TDATA/AXIS_TVALID hold in OUT until AXIS_TREADY; no data lost.
//
// Optional build macro: CONV_ENGINE_RELU_EN clamps negative results to 0.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   inputs_loaded, K, B        - job start; K and B captured when the job starts
//   X_read_addr / X_data       - X memory, row-major, data one cycle after address
//   W_read_addr / W_data       - W memory, row-major stride K, data one cycle later
//   AXIS_TDATA/TVALID/TREADY   - output stream, row-major Y words
//   compute_finished           - one-cycle pulse at the end of each job
module conv_engine
   import conv_pkg::*;
#(
   parameter int INW  = 24,
   parameter int R    = 9,
   parameter int C    = 8,
   parameter int MAXK = 4,
   parameter int OUTW = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          inputs_loaded,
   input  logic [$clog2(MAXK+1)-1:0]     K,
   input  logic [INW-1:0]                B,
   output logic [$clog2(R*C)-1:0]        X_read_addr,
   input  logic [INW-1:0]                X_data,
   output logic [$clog2(MAXK*MAXK)-1:0]  W_read_addr,
   input  logic [INW-1:0]                W_data,
   output logic                          compute_finished,
   output logic [OUTW-1:0]               AXIS_TDATA,
   output logic                          AXIS_TVALID,
   input  logic                          AXIS_TREADY
);

   localparam int ACCW = calc_accw(INW, MAXK);
   localparam int KW   = $clog2(MAXK + 1);
   localparam int XAW  = $clog2(R * C);
   localparam int WAW  = $clog2(MAXK * MAXK);
   localparam int RW   = (R > 1) ? $clog2(R) : 1;
   localparam int CW   = (C > 1) ? $clog2(C) : 1;

   conv_state_t     state, state_nxt;
   logic [KW-1:0]   k_q, i_q, j_q;
   logic [INW-1:0]  b_q;
   logic [RW-1:0]   r_q;
   logic [CW-1:0]   c_q;
   logic            en_q;
   logic [ACCW-1:0] acc;

   logic            k_ok, start_job, kern_last, row_last, out_last, fire;
   logic            mac_load, mac_clear;
   logic [INW-1:0]  load_val;
   logic [OUTW-1:0] y_word;
   logic            unused_acc_hi;

   assign k_ok      = (K >= KW'(2)) && (int'(K) <= MAXK);
   assign kern_last = (i_q == k_q - KW'(1)) && (j_q == k_q - KW'(1));
   assign row_last  = (int'(c_q) == C - int'(k_q));
   assign out_last  = row_last && (int'(r_q) == R - int'(k_q));
   assign fire      = (state == OUT) && AXIS_TREADY;
   assign mac_clear = (state == DONE);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and per-cycle controls
   always_comb begin
      state_nxt = state;
      start_job = 1'b0;
      mac_load  = 1'b0;
      load_val  = b_q;
      case (state)
         IDLE: begin
            if (inputs_loaded) begin
               if (k_ok) begin
                  state_nxt = FETCH;
                  start_job = 1'b1;
                  mac_load  = 1'b1;
                  load_val  = B;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         FETCH: begin
            if (kern_last) state_nxt = DRAIN;
         end
         DRAIN: state_nxt = OUT;
         OUT: begin
            if (AXIS_TREADY) begin
               if (out_last) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = FETCH;
                  mac_load  = 1'b1;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Job parameters, kernel and output position counters.
   // en_q marks the cycle in which the word fetched last cycle is on X_data/W_data.
   always_ff @(posedge clk) begin
      if (reset) begin
         k_q  <= '0;
         b_q  <= '0;
         i_q  <= '0;
         j_q  <= '0;
         r_q  <= '0;
         c_q  <= '0;
         en_q <= 1'b0;
      end else begin
         en_q <= (state == FETCH);
         if (start_job) begin
            k_q <= K;
            b_q <= B;
            i_q <= '0;
            j_q <= '0;
            r_q <= '0;
            c_q <= '0;
         end else if (state == FETCH) begin
            if (j_q == k_q - KW'(1)) begin
               j_q <= '0;
               i_q <= kern_last ? '0 : i_q + KW'(1);
            end else begin
               j_q <= j_q + KW'(1);
            end
         end else if (fire && !out_last) begin
            if (row_last) begin
               c_q <= '0;
               r_q <= r_q + RW'(1);
            end else begin
               c_q <= c_q + CW'(1);
            end
         end
      end
   end

   // Addresses are only driven while fetching; zero otherwise.
   always_comb begin
      X_read_addr = '0;
      W_read_addr = '0;
      if (state == FETCH) begin
         X_read_addr = (XAW'(r_q) + XAW'(i_q)) * XAW'(C) + XAW'(c_q) + XAW'(j_q);
         W_read_addr = WAW'(i_q) * WAW'(k_q) + WAW'(j_q);
      end
   end

   conv_mac #(
      .INW  (INW),
      .MAXK (MAXK),
      .ACCW (ACCW)
   ) u_mac (
      .clk      (clk),
      .reset    (reset),
      .clear    (mac_clear),
      .load     (mac_load),
      .load_val (load_val),
      .en       (en_q),
      .x_in     (X_data),
      .w_in     (W_data),
      .acc      (acc)
   );

`ifdef CONV_ENGINE_RELU_EN
   assign y_word = acc[ACCW-1] ? '0 : acc[OUTW-1:0];
`else
   assign y_word = acc[OUTW-1:0];
`endif

   // Upper accumulator bits only matter for the sign test.
   assign unused_acc_hi = ^acc[ACCW-1:OUTW];

   assign AXIS_TVALID      = (state == OUT);
   assign AXIS_TDATA       = (state == OUT) ? y_word : '0;
   assign compute_finished = (state == DONE);

endmodule

// File: tb/tb_conv_engine.sv
// Randomized bench for conv_engine with a behavioural convolution model.
module tb_conv_engine;

   localparam int INW  = 24;
   localparam int R    = 9;
   localparam int C    = 8;
   localparam int MAXK = 4;
   localparam int OUTW = 32;
   localparam int KW   = $clog2(MAXK + 1);
   localparam int XAW  = $clog2(R * C);
   localparam int WAW  = $clog2(MAXK * MAXK);

   logic            clk;
   logic            reset;
   logic            inputs_loaded;
   logic [KW-1:0]   K;
   logic [INW-1:0]  B;
   logic [XAW-1:0]  X_read_addr;
   logic [INW-1:0]  X_data;
   logic [WAW-1:0]  W_read_addr;
   logic [INW-1:0]  W_data;
   logic            compute_finished;
   logic [OUTW-1:0] AXIS_TDATA;
   logic            AXIS_TVALID;
   logic            AXIS_TREADY;

   conv_engine #(
      .INW(INW), .R(R), .C(C), .MAXK(MAXK), .OUTW(OUTW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .inputs_loaded    (inputs_loaded),
      .K                (K),
      .B                (B),
      .X_read_addr      (X_read_addr),
      .X_data           (X_data),
      .W_read_addr      (W_read_addr),
      .W_data           (W_data),
      .compute_finished (compute_finished),
      .AXIS_TDATA       (AXIS_TDATA),
      .AXIS_TVALID      (AXIS_TVALID),
      .AXIS_TREADY      (AXIS_TREADY)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous-read memories
   logic [INW-1:0] xm [0:(1<<XAW)-1];
   logic [INW-1:0] wm [0:(1<<WAW)-1];

   always @(posedge clk) begin
      X_data <= xm[X_read_addr];
      W_data <= wm[W_read_addr];
   end

   logic [OUTW-1:0] exp_q[$];
   logic [OUTW-1:0] mdl_q[$];
   logic [OUTW-1:0] got_q[$];
   logic [OUTW-1:0] prev_dat;
   logic [OUTW-1:0] cmp_e;
   bit              have_prev;
   int              out_count, done_count, stall5;
   int              pass_cnt, chk_cnt;
   int              ready_mode;
   bit              stall_armed;
   int              stall_left;

   task automatic check(input bit ok, input string name, input longint act, input longint req);
      chk_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   // Y[r][c] = B + sum W[i*K+j]*X[(r+i)*C+c+j], row-major, low OUTW bits
   task automatic build_model(input int k, input int b);
      longint a;
      logic [OUTW-1:0] y;
      exp_q.delete();
      mdl_q.delete();
      if (k >= 2 && k <= MAXK) begin
         for (int r = 0; r <= R - k; r++) begin
            for (int c = 0; c <= C - k; c++) begin
               a = b;
               for (int i = 0; i < k; i++)
                  for (int j = 0; j < k; j++)
                     a += longint'($signed(wm[i*k+j])) * longint'($signed(xm[(r+i)*C + c + j]));
`ifdef CONV_ENGINE_RELU_EN
               if (a < 0) a = 0;
`endif
               y = a[OUTW-1:0];
               exp_q.push_back(y);
               mdl_q.push_back(y);
            end
         end
      end
   endtask

   task automatic fill_random();
      logic [31:0] t;
      for (int n = 0; n < R * C; n++) begin
         t = $urandom;
         xm[n] = t[INW-1:0];
      end
      for (int n = 0; n < MAXK * MAXK; n++) begin
         t = $urandom;
         wm[n] = t[INW-1:0];
      end
   endtask

   task automatic start_job(input int k, input int b, input bit scramble);
      logic [31:0] t;
      @(negedge clk);
      K = k[KW-1:0];
      B = b[INW-1:0];
      inputs_loaded = 1'b1;
      @(posedge clk);
      #1;
      inputs_loaded = 1'b0;
      if (scramble) begin
         t = $urandom;
         K = t[KW-1:0];
         B = t[INW+7:8];
      end
   endtask

   task automatic run_job(input int k, input int b, input bit scramble);
      int  n, n_exp;
      bit  seen;
      got_q.delete();
      out_count = 0;
      build_model(k, b);
      n_exp = exp_q.size();
      start_job(k, b, scramble);
      n = 0;
      seen = 0;
      while (!seen && n < 5000) begin
         @(negedge clk);
         n++;
         if (AXIS_TVALID || compute_finished) seen = 1;
      end
      if (n_exp > 0) begin
         check(AXIS_TVALID && n == k * k + 2, "first_valid_latency", n, k * k + 2);
         n = 0;
         seen = 0;
         while (!seen && n < 20000) begin
            @(negedge clk);
            n++;
            if (compute_finished) seen = 1;
         end
         check(seen, "job_done_timeout", n, 20000);
      end else begin
         check(compute_finished && n <= 2, "badk_finish_latency", n, 2);
      end
      check(out_count == n_exp, "output_count", out_count, n_exp);
      @(negedge clk);
      check(!compute_finished, "finish_pulse_width", compute_finished, 0);
   endtask

   // Output monitor: every handshake checked against the model, stalls checked for stability
   always @(negedge clk) begin
      if (reset) begin
         have_prev = 0;
      end else begin
         if (have_prev) begin
            check(AXIS_TVALID, "valid_held", AXIS_TVALID, 1);
            if (AXIS_TVALID) check(AXIS_TDATA == prev_dat, "tdata_stable", AXIS_TDATA, prev_dat);
         end
         have_prev = 0;
         if (AXIS_TVALID) begin
            if (!AXIS_TREADY && out_count == 5) stall5++;
            if (AXIS_TREADY) begin
               check(exp_q.size() != 0, "extra_output", AXIS_TDATA, 0);
               if (exp_q.size() != 0) begin
                  cmp_e = exp_q.pop_front();
                  check(AXIS_TDATA == cmp_e, "y_value", AXIS_TDATA, cmp_e);
               end
               got_q.push_back(AXIS_TDATA);
               out_count++;
            end else begin
               have_prev = 1;
               prev_dat  = AXIS_TDATA;
            end
         end
         if (compute_finished) begin
            check(exp_q.size() == 0, "finish_with_pending", exp_q.size(), 0);
            done_count++;
         end
      end
   end

   // AXIS_TREADY driver: random or always-ready, with an optional 20-cycle stall on output 5
   initial begin
      AXIS_TREADY = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (stall_left > 0) begin
            AXIS_TREADY = 1'b0;
            stall_left--;
         end else if (stall_armed && out_count == 5 && AXIS_TVALID) begin
            stall_armed = 0;
            stall_left  = 19;
            AXIS_TREADY = 1'b0;
         end else begin
            AXIS_TREADY = (ready_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc, n;
      logic [31:0] t;
      int bv, kv;
      logic [OUTW-1:0] neg16;
      pass_cnt = 0; chk_cnt = 0; out_count = 0; done_count = 0; stall5 = 0;
      ready_mode = 1; stall_armed = 0; stall_left = 0; have_prev = 0;
      reset = 1'b1; inputs_loaded = 1'b0; K = '0; B = '0;
      for (int q = 0; q < (1 << XAW); q++) xm[q] = '0;
      for (int q = 0; q < (1 << WAW); q++) wm[q] = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check(AXIS_TVALID == 1'b0, "rst_tvalid", AXIS_TVALID, 0);
      check(compute_finished == 1'b0, "rst_finished", compute_finished, 0);
      check(AXIS_TDATA == '0, "rst_tdata", AXIS_TDATA, 0);
      check(X_read_addr == '0, "rst_xaddr", X_read_addr, 0);
      check(W_read_addr == '0, "rst_waddr", W_read_addr, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // K=3, B=5, X=1, W=2: 42 outputs of 5+9*2=23
      for (int q = 0; q < R * C; q++) xm[q] = 24'd1;
      for (int q = 0; q < 9; q++) wm[q] = 24'd2;
      ready_mode = 0;
      run_job(3, 5, 1'b0);
      check(mdl_q.size() == 42 && mdl_q[0] == 32'd23, "model_pin_ones", mdl_q[0], 23);
      check(got_q.size() == 42, "ones_count", got_q.size(), 42);
      if (got_q.size() == 42) begin
         check(got_q[0] == 32'd23, "ones_first", got_q[0], 23);
         check(got_q[41] == 32'd23, "ones_last", got_q[41], 23);
      end

      // K=2, X[n]=n, W={1,0,0,1}: Y[r][c] = X[r*8+c] + X[(r+1)*8+c+1]
      for (int q = 0; q < R * C; q++) xm[q] = q[INW-1:0];
      wm[0] = 24'd1; wm[1] = 24'd0; wm[2] = 24'd0; wm[3] = 24'd1;
      run_job(2, 0, 1'b1);
      check(mdl_q.size() == 56 && mdl_q[48] == 32'd117, "model_pin_ramp", mdl_q[48], 117);
      check(got_q.size() == 56, "ramp_count", got_q.size(), 56);
      if (got_q.size() == 56) begin
         check(got_q[0] == 32'd9, "ramp_y00", got_q[0], 9);      // 0 + 9
         check(got_q[48] == 32'd117, "ramp_y66", got_q[48], 117); // 54 + 63
         check(got_q[55] == 32'd133, "ramp_y76", got_q[55], 133); // 62 + 71
      end

      // K=4, W=-1, X=1: -16 per output, or 0 when clamped
      for (int q = 0; q < R * C; q++) xm[q] = 24'd1;
      for (int q = 0; q < 16; q++) wm[q] = 24'hFFFFFF;
`ifdef CONV_ENGINE_RELU_EN
      neg16 = 32'd0;
`else
      neg16 = 32'hFFFF_FFF0;
`endif
      run_job(4, 0, 1'b0);
      check(got_q.size() == 30, "neg_count", got_q.size(), 30);
      if (got_q.size() == 30) begin
         check(got_q[0] == neg16, "neg_first", got_q[0], neg16);
         check(got_q[29] == neg16, "neg_last", got_q[29], neg16);
      end

      // K=3 with a 20-cycle stall on output 5
      fill_random();
      ready_mode = 1;
      stall5 = 0;
      stall_armed = 1;
      t = $urandom;
      bv = int'($signed(t[INW-1:0]));
      run_job(3, bv, 1'b0);
      check(stall5 == 20, "stall_cycles", stall5, 20);
      check(got_q.size() == 42, "stall_count", got_q.size(), 42);

      // Out-of-range K: no outputs, quick finish
      run_job(1, 7, 1'b0);
      run_job(0, 7, 1'b0);
      run_job(5, 7, 1'b0);

      // Reset during FETCH of output 10, then a fresh job
      fill_random();
      ready_mode = 1;
      got_q.delete();
      out_count = 0;
      build_model(3, 11);
      start_job(3, 11, 1'b0);
      n = 0;
      while (out_count < 10 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check(out_count == 10, "reach_output10", out_count, 10);
      repeat (2) @(negedge clk);
      dc = done_count;
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check(AXIS_TVALID == 1'b0, "midrst_tvalid", AXIS_TVALID, 0);
      check(compute_finished == 1'b0, "midrst_finished", compute_finished, 0);
      check(X_read_addr == '0, "midrst_xaddr", X_read_addr, 0);
      repeat (10) @(negedge clk);
      check(done_count == dc, "midrst_no_finish", done_count, dc);
      run_job(3, 11, 1'b0);
      check(got_q.size() == 42, "restart_count", got_q.size(), 42);

      // Random jobs with random backpressure and inputs changing after start
      ready_mode = 0;
      for (int q = 0; q < 4; q++) begin
         fill_random();
         t = $urandom;
         bv = int'($signed(t[INW-1:0]));
         kv = $urandom_range(2, MAXK);
         run_job(kv, bv, 1'b1);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
